// File: rtl/risky_uart_pkg.sv
// Shared types and default sizes for the UART transmit arbiter.
// Optional statistics counters are enabled by defining UART_ARB_STATS_EN.
package risky_uart_pkg;

    localparam int BYTE_CYCLES_DEFAULT = 8681;
    localparam int FIFO_DEPTH_DEFAULT  = 16;

    // Which requester received the most recent push.
    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_DBG = 1'b1
    } grant_e;

    // Drain pacing states.
    typedef enum logic {
        IDLE = 1'b0,
        GAP  = 1'b1
    } drain_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte request handshakes from the CPU store path and the debug source.
// The producer side uses the master modport; the arbiter uses slave.
interface uart_tx_arbiter_if;

    logic       cpu_valid;
    logic [7:0] cpu_data;
    logic       cpu_ready;
    logic       dbg_valid;
    logic [7:0] dbg_data;
    logic       dbg_ready;

    modport master (
        output cpu_valid, cpu_data, dbg_valid, dbg_data,
        input  cpu_ready, dbg_ready
    );

    modport slave (
        input  cpu_valid, cpu_data, dbg_valid, dbg_data,
        output cpu_ready, dbg_ready
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Single-clock byte FIFO with registered occupancy.
// Read data is presented from the head entry so the drain logic can capture
// it on the same edge it pops.
module uart_tx_fifo
    import risky_uart_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rstd,
    input  logic                     push_i,
    input  logic [7:0]               push_data_i,
    input  logic                     pop_i,
    output logic [7:0]               rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          push_ok, pop_ok;

    // Overflow/underflow requests are ignored rather than corrupting state.
    assign push_ok = push_i && (level_q != LEVEL_FULL);
    assign pop_ok  = pop_i  && (level_q != '0);

    // Pointer and level next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            level_d = level_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            level_d = level_q - 1'b1;
        end
    end

    // Storage write; contents need no reset since level gates all reads.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign full_o    = (level_q == LEVEL_FULL);
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between the CPU store path and a debug source.
// Round-robin arbitration on ties, a byte FIFO, and a drain FSM that spaces
// write strobes exactly BYTE_CYCLES apart (the UART has no busy flag).
// Define UART_ARB_STATS_EN to add tx_count and cpu_stall_cycles outputs.
module uart_tx_arbiter
    import risky_uart_pkg::*;
#(
    parameter int DEPTH       = FIFO_DEPTH_DEFAULT,
    parameter int BYTE_CYCLES = BYTE_CYCLES_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rstd,
    uart_tx_arbiter_if.slave       req_if,
    output logic                   uart_wr_o,
    output logic [7:0]             uart_dat_o,
    output logic [$clog2(DEPTH):0] fifo_level
`ifdef UART_ARB_STATS_EN
    ,
    output logic [15:0]            tx_count,
    output logic [15:0]            cpu_stall_cycles
`endif
);

    localparam int GW = $clog2(BYTE_CYCLES);
    localparam logic [GW-1:0] GAP_RELOAD = GW'(BYTE_CYCLES - 2);

    grant_e       last_grant_q, last_grant_d;
    drain_state_e state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          wr_q, wr_d;
    logic [7:0]    dat_q, dat_d;

    logic          fifo_full, fifo_empty;
    logic [7:0]    fifo_rd_data;
    logic [$clog2(DEPTH):0] level;
    logic          cpu_grant, dbg_grant;
    logic          push, pop;
    logic [7:0]    push_data;

    uart_tx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rstd        (rstd),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .rd_data_o   (fifo_rd_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (level)
    );

    // Ready generation from registered occupancy; alternate grants on a tie.
    always_comb begin
        cpu_grant = 1'b0;
        dbg_grant = 1'b0;
        if (req_if.cpu_valid && req_if.dbg_valid) begin
            if (last_grant_q == GNT_DBG) begin
                cpu_grant = !fifo_full;
            end else begin
                dbg_grant = !fifo_full;
            end
        end else if (req_if.cpu_valid) begin
            cpu_grant = !fifo_full;
        end else if (req_if.dbg_valid) begin
            dbg_grant = !fifo_full;
        end
    end

    assign req_if.cpu_ready = cpu_grant;
    assign req_if.dbg_ready = dbg_grant;

    // Push selection and grant history, which moves only on a real push.
    always_comb begin
        push         = 1'b0;
        push_data    = req_if.cpu_data;
        last_grant_d = last_grant_q;
        if (req_if.cpu_valid && cpu_grant) begin
            push         = 1'b1;
            push_data    = req_if.cpu_data;
            last_grant_d = GNT_CPU;
        end else if (req_if.dbg_valid && dbg_grant) begin
            push         = 1'b1;
            push_data    = req_if.dbg_data;
            last_grant_d = GNT_DBG;
        end
    end

    // Drain FSM: launch a byte from IDLE, then count out the byte-time in GAP.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        wr_d    = 1'b0;
        dat_d   = dat_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    wr_d    = 1'b1;
                    dat_d   = fifo_rd_data;
                    gap_d   = GAP_RELOAD;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbitration and drain state registers.
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            last_grant_q <= GNT_DBG;
            state_q      <= IDLE;
            gap_q        <= '0;
            wr_q         <= 1'b0;
            dat_q        <= 8'h00;
        end else begin
            last_grant_q <= last_grant_d;
            state_q      <= state_d;
            gap_q        <= gap_d;
            wr_q         <= wr_d;
            dat_q        <= dat_d;
        end
    end

    assign uart_wr_o  = wr_q;
    assign uart_dat_o = dat_q;
    assign fifo_level = level;

`ifdef UART_ARB_STATS_EN
    logic [15:0] tx_count_q;
    logic [15:0] stall_q;

    // Strobe count (wrapping) and CPU stall cycles (saturating).
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            tx_count_q <= 16'h0000;
            stall_q    <= 16'h0000;
        end else begin
            if (pop) begin
                tx_count_q <= tx_count_q + 16'd1;
            end
            if (req_if.cpu_valid && !cpu_grant && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    assign tx_count         = tx_count_q;
    assign cpu_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter against a queue-based reference model.
// Build with UART_ARB_STATS_EN defined to also check the statistics outputs.
module tb_uart_tx_arbiter;
    import risky_uart_pkg::*;

    localparam int DEPTH       = 4;
    localparam int BYTE_CYCLES = 10;
    localparam int LW          = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rstd;
    always #5 clk = ~clk;

    uart_tx_arbiter_if bus_if ();
    logic          uart_wr_o;
    logic [7:0]    uart_dat_o;
    logic [LW-1:0] fifo_level;
`ifdef UART_ARB_STATS_EN
    logic [15:0]   tx_count;
    logic [15:0]   cpu_stall_cycles;
`endif

    uart_tx_arbiter #(
        .DEPTH       (DEPTH),
        .BYTE_CYCLES (BYTE_CYCLES)
    ) dut (
        .clk              (clk),
        .rstd             (rstd),
        .req_if           (bus_if),
        .uart_wr_o        (uart_wr_o),
        .uart_dat_o       (uart_dat_o),
        .fifo_level       (fifo_level)
`ifdef UART_ARB_STATS_EN
        ,
        .tx_count         (tx_count),
        .cpu_stall_cycles (cpu_stall_cycles)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: queue contents, grant history, earliest next launch.
    logic [7:0] m_q[$];
    bit         m_last_dbg;
    int         m_edge;
    int         m_earliest;
    logic [7:0] m_dat;
    int         m_tx;
    int         m_stall;

    // Strobes observed, for the directed tests.
    int         s_edge[$];
    logic [7:0] s_data[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_last_dbg = 1'b1;
        m_edge     = 0;
        m_earliest = 0;
        m_dat      = 8'h00;
        m_tx       = 0;
        m_stall    = 0;
    endtask

    // One clock cycle: drive requests, check readies, advance the model,
    // then check the registered outputs just after the edge.
    task automatic step(input bit cv, input logic [7:0] cd, input bit dv, input logic [7:0] dd,
                        output bit cacc, output bit dacc);
        bit space, exp_cr, exp_dr, do_pop;
        bus_if.cpu_valid = cv;
        bus_if.cpu_data  = cd;
        bus_if.dbg_valid = dv;
        bus_if.dbg_data  = dd;
        #1;
        space  = (m_q.size() != DEPTH);
        exp_cr = 1'b0;
        exp_dr = 1'b0;
        if (cv && dv) begin
            if (m_last_dbg) exp_cr = space;
            else            exp_dr = space;
        end else if (cv) begin
            exp_cr = space;
        end else if (dv) begin
            exp_dr = space;
        end
        check_eq("cpu_ready", 32'(bus_if.cpu_ready), 32'(exp_cr));
        check_eq("dbg_ready", 32'(bus_if.dbg_ready), 32'(exp_dr));
        cacc = cv && exp_cr;
        dacc = dv && exp_dr;
        if (cv && !exp_cr && m_stall < 16'hFFFF) m_stall++;

        do_pop = (m_q.size() != 0) && (m_edge >= m_earliest);
        if (do_pop) begin
            m_dat      = m_q.pop_front();
            m_earliest = m_edge + BYTE_CYCLES;
            m_tx++;
        end
        if (cacc) begin
            m_q.push_back(cd);
            m_last_dbg = 1'b0;
        end else if (dacc) begin
            m_q.push_back(dd);
            m_last_dbg = 1'b1;
        end

        @(posedge clk);
        m_edge++;
        #1;
        check_eq("uart_wr_o", 32'(uart_wr_o), 32'(do_pop));
        check_eq("uart_dat_o", 32'(uart_dat_o), 32'(m_dat));
        check_eq("fifo_level", 32'(fifo_level), 32'(m_q.size()));
`ifdef UART_ARB_STATS_EN
        check_eq("tx_count", 32'(tx_count), 32'(m_tx & 16'hFFFF));
        check_eq("cpu_stall_cycles", 32'(cpu_stall_cycles), 32'(m_stall));
`endif
        if (uart_wr_o === 1'b1) begin
            s_edge.push_back(m_edge);
            s_data.push_back(uart_dat_o);
            $display("TX byte 0x%02h at edge %0d level %0d", uart_dat_o, m_edge, fifo_level);
        end
    endtask

    task automatic idle_steps(input int n);
        bit ca, da;
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 8'h00, ca, da);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once.
    task automatic apply_reset();
        #2;
        bus_if.cpu_valid = 1'b0;
        bus_if.dbg_valid = 1'b0;
        bus_if.cpu_data  = 8'h00;
        bus_if.dbg_data  = 8'h00;
        rstd = 1'b0;
        #1;
        check_eq("rst_uart_wr_o", 32'(uart_wr_o), 32'd0);
        check_eq("rst_uart_dat_o", 32'(uart_dat_o), 32'd0);
        check_eq("rst_fifo_level", 32'(fifo_level), 32'd0);
`ifdef UART_ARB_STATS_EN
        check_eq("rst_tx_count", 32'(tx_count), 32'd0);
        check_eq("rst_cpu_stall", 32'(cpu_stall_cycles), 32'd0);
`endif
        @(posedge clk);
        @(negedge clk);
        rstd = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        s_edge.delete();
        s_data.delete();
        $display("RESET released at %0t", $time);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ca, da;
        logic [7:0] cbyte, dbyte;
        logic [7:0] acc[$];
        int max_lvl;
        bit pend_c, pend_d;
        logic [7:0] pc, pd;
        bit cv, dv;
        int pc_prob, pd_prob;

        rstd = 1'b1;
        bus_if.cpu_valid = 1'b0;
        bus_if.dbg_valid = 1'b0;
        bus_if.cpu_data  = 8'h00;
        bus_if.dbg_data  = 8'h00;
        model_reset();
        @(posedge clk);
        #1;
        apply_reset();

        // Single byte: accepted at once, strobe two edges later.
        step(1'b1, 8'h41, 1'b0, 8'h00, ca, da);
        check_eq("single_accept", 32'(ca), 32'd1);
        step(1'b0, 8'h00, 1'b0, 8'h00, ca, da);
        check_eq("single_strobe", 32'(uart_wr_o), 32'd1);
        check_eq("single_data", 32'(uart_dat_o), 32'h41);
        idle_steps(12);
        check_eq("single_level", 32'(fifo_level), 32'd0);
        check_eq("single_count", 32'(s_edge.size()), 32'd1);

        // Pacing: three bytes, strobes exactly BYTE_CYCLES apart, in order.
        apply_reset();
        for (int i = 1; i <= 3; i++) step(1'b1, 8'(i), 1'b0, 8'h00, ca, da);
        idle_steps(35);
        check_eq("pace_count", 32'(s_edge.size()), 32'd3);
        if (s_edge.size() == 3) begin
            check_eq("pace_gap1", 32'(s_edge[1] - s_edge[0]), 32'(BYTE_CYCLES));
            check_eq("pace_gap2", 32'(s_edge[2] - s_edge[1]), 32'(BYTE_CYCLES));
            for (int i = 0; i < 3; i++) check_eq("pace_data", 32'(s_data[i]), 32'(i + 1));
        end

        // Tie round-robin: CPU first after reset, then strict alternation.
        apply_reset();
        cbyte = 8'hA0;
        dbyte = 8'hB0;
        acc.delete();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, cbyte, 1'b1, dbyte, ca, da);
            if (ca) begin acc.push_back(cbyte); cbyte++; end
            if (da) begin acc.push_back(dbyte); dbyte++; end
        end
        check_eq("tie_count", 32'(acc.size()), 32'd4);
        if (acc.size() == 4) begin
            check_eq("tie_0", 32'(acc[0]), 32'hA0);
            check_eq("tie_1", 32'(acc[1]), 32'hB0);
            check_eq("tie_2", 32'(acc[2]), 32'hA1);
            check_eq("tie_3", 32'(acc[3]), 32'hB1);
        end
        idle_steps(50);

        // Full: CPU holds valid until the FIFO fills and stalls.
        apply_reset();
        cbyte   = 8'h10;
        max_lvl = 0;
        acc.delete();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, cbyte, 1'b0, 8'h00, ca, da);
            if (ca) begin acc.push_back(cbyte); cbyte++; end
            if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
        end
        check_eq("full_max_level", 32'(max_lvl), 32'(DEPTH));
        idle_steps(BYTE_CYCLES * (DEPTH + 3));
        check_eq("full_bytes_out", 32'(s_data.size()), 32'(acc.size()));
        for (int i = 0; i < acc.size() && i < s_data.size(); i++)
            check_eq("full_order", 32'(s_data[i]), 32'(acc[i]));

        // Reset during GAP with bytes queued: nothing comes out afterwards.
        apply_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 8'h00, ca, da);
        step(1'b0, 8'h00, 1'b0, 8'h00, ca, da);
        check_eq("midrst_level", 32'(fifo_level), 32'd3);
        apply_reset();
        idle_steps(3 * BYTE_CYCLES);
        check_eq("midrst_no_strobe", 32'(s_edge.size()), 32'd0);

        // Randomized traffic with alternating light/heavy phases.
        apply_reset();
        pend_c = 1'b0;
        pend_d = 1'b0;
        pc = 8'h00;
        pd = 8'h00;
        for (int i = 0; i < 1200; i++) begin
            pc_prob = ((i / 150) % 2 == 1) ? 70 : 12;
            pd_prob = ((i / 100) % 2 == 1) ? 60 : 8;
            if (pend_c) cv = 1'b1;
            else begin
                cv = ($urandom_range(99) < pc_prob);
                pc = 8'($urandom);
            end
            if (pend_d) dv = 1'b1;
            else begin
                dv = ($urandom_range(99) < pd_prob);
                pd = 8'($urandom);
            end
            step(cv, pc, dv, pd, ca, da);
            pend_c = cv && !ca;
            pend_d = dv && !da;
        end
        idle_steps(BYTE_CYCLES * (DEPTH + 2));
        check_eq("final_level", 32'(fifo_level), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
